// File: rtl/siso_frame_ctrl.sv
// -----------------------------------------------------------------------------
// siso_frame_ctrl
//   Sequencer for a DEPTH-stage serial-in serial-out shift register. A WIDTH-bit
//   word is taken on a start/ready handshake and fed to the chain one bit per
//   clock. DEPTH further zero shifts then flush the chain. out_valid marks the
//   cycles in which the chain output carries a frame bit. done pulses once the
//   whole frame has left the chain.
//
//   Optional feature macro: SISO_PARITY_EN. When it is defined, an even-parity
//   bit (XOR of the data bits) follows the data, so each frame has WIDTH+1 bits.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      asynchronous reset, active low
//   start     in   1      frame request, accepted when start & ready
//   data_in   in   WIDTH  frame word, sampled on the accept edge only
//   abort     in   1      cancel the frame in progress (beats start)
//   ready     out  1      idle, a start will be accepted
//   shift_en  out  1      chain shift enable (registered)
//   sdin      out  1      serial bit to the chain input (registered)
//   out_valid out  1      chain output holds a frame bit this cycle
//   bit_cnt   out  CW     index of the frame bit on sdin, 0 outside SHIFT
//   done      out  1      one-cycle pulse, frame complete
// -----------------------------------------------------------------------------
module siso_frame_ctrl #(
  parameter int  WIDTH     = 8,
  parameter int  DEPTH     = 4,
  parameter int  MSB_FIRST = 1,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             abort,
  output logic             ready,
  output logic             shift_en,
  output logic             sdin,
  output logic             out_valid,
  output logic [CW-1:0]    bit_cnt,
  output logic             done
);

`ifdef SISO_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  // One counter serves both the bit index (SHIFT) and the flush count (FLUSH).
  localparam int CNT_MAX = (NB > DEPTH) ? NB : DEPTH;
  localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(NB);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] src;
  logic [NB-1:0]    frame_vec;
  logic [DEPTH-1:0] vpipe;

  logic             ready_nxt;
  logic             shift_en_nxt;
  logic             sdin_nxt;
  logic [CW-1:0]    bit_cnt_nxt;
  logic             done_nxt;

  // State register. All outputs are registered here from their *_nxt values,
  // so each output changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the shadow word and the valid pipeline are small, so they are
      // reset with the control state; nothing downstream then ever sees stale
      // frame data after a reset.
      state    <= IDLE;
      cnt      <= '0;
      shadow   <= '0;
      vpipe    <= '0;
      ready    <= 1'b1;
      shift_en <= 1'b0;
      sdin     <= 1'b0;
      bit_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only in clocked blocks, so every
      // register samples the pre-edge value of every other register.
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && state_nxt == SHIFT) shadow <= data_in;

      // vpipe[0] records "a frame bit entered the chain last cycle"; after
      // DEPTH shifts that bit appears on the chain output.
      if (abort && state != IDLE) vpipe <= '0;
      else                        vpipe <= (vpipe << 1) | DEPTH'(state == SHIFT);

      ready    <= ready_nxt;
      shift_en <= shift_en_nxt;
      sdin     <= sdin_nxt;
      bit_cnt  <= bit_cnt_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state logic. abort out of any busy state wins over everything else;
  // in IDLE it only masks start.
  always_comb begin
    // NOTE: defaults first, so every path assigns every signal and no latch
    // can be inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: if (start && !abort) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
        SHIFT: if (cnt == CNTW'(NB - 1)) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
        FLUSH: if (cnt == CNTW'(DEPTH - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
        DONE: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic, computed from the next state so the registered outputs line
  // up with it. On the accept edge the shadow is not loaded yet, so the first
  // bit is taken straight from data_in.
  always_comb begin
    src = (state == IDLE) ? data_in : shadow;
    for (int i = 0; i < WIDTH; i++)
      frame_vec[i] = (MSB_FIRST != 0) ? src[WIDTH-1-i] : src[i];
`ifdef SISO_PARITY_EN
    frame_vec[WIDTH] = ^src;
`endif
    ready_nxt    = (state_nxt == IDLE);
    shift_en_nxt = (state_nxt == SHIFT) || (state_nxt == FLUSH);
    sdin_nxt     = (state_nxt == SHIFT) && frame_vec[cnt_nxt[IW-1:0]];
    bit_cnt_nxt  = (state_nxt == SHIFT) ? CW'(cnt_nxt) : '0;
    done_nxt     = (state_nxt == DONE);
  end

  assign out_valid = vpipe[DEPTH-1];

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_siso_frame_ctrl
//   Bench for siso_frame_ctrl. Two instances share all inputs: one sends MSB
//   first and one LSB first. Each cycle's expected outputs come from a model
//   that works only from the frame timeline: the cycle index k after the
//   accept edge, the frame word, and the abort cycle.
// -----------------------------------------------------------------------------
module tb_siso_frame_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef SISO_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int CW        = $clog2(WIDTH + 1);
  localparam int FRAME_LEN = NB + DEPTH + 2;   // accept edge to first idle cycle

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] data_in = '0;

  logic          ready_m, shift_en_m, sdin_m, out_valid_m, done_m;
  logic [CW-1:0] bit_cnt_m;
  logic          ready_l, shift_en_l, sdin_l, out_valid_l, done_l;
  logic [CW-1:0] bit_cnt_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  siso_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .abort(abort),
    .ready(ready_m), .shift_en(shift_en_m), .sdin(sdin_m),
    .out_valid(out_valid_m), .bit_cnt(bit_cnt_m), .done(done_m)
  );

  siso_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .abort(abort),
    .ready(ready_l), .shift_en(shift_en_l), .sdin(sdin_l),
    .out_valid(out_valid_l), .bit_cnt(bit_cnt_l), .done(done_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i of the serial frame: data bits in send order, then the parity bit.
  function automatic logic model_bit(input logic [WIDTH-1:0] w, input bit msb, input int i);
    logic [WIDTH-1:0] t;
    if (i >= WIDTH) return ^w;
    t = w >> (msb ? (WIDTH - 1 - i) : i);
    return t[0];
  endfunction

  // Expected outputs in cycle k after the accept edge (k=0: idle / reset).
  // abort_k = cycle in which abort is held (0 = none); from k > abort_k on
  // the block is idle again.
  task automatic check_cycle(input string tag, input int k, input logic [WIDTH-1:0] w,
                             input int abort_k);
    bit live, in_data, busy;
    bit e_shift, e_valid, e_done, e_ready, e_sdin_m, e_sdin_l;
    int e_cnt;
    live     = (abort_k == 0) || (k <= abort_k);
    in_data  = live && (k >= 1) && (k <= NB);
    busy     = live && (k >= 1) && (k <= NB + DEPTH + 1);
    e_shift  = live && (k >= 1) && (k <= NB + DEPTH);
    e_valid  = live && (k > DEPTH) && (k <= NB + DEPTH);
    e_done   = live && (k == NB + DEPTH + 1);
    e_ready  = !busy;
    e_cnt    = in_data ? (k - 1) : 0;
    e_sdin_m = in_data ? model_bit(w, 1'b1, k - 1) : 1'b0;
    e_sdin_l = in_data ? model_bit(w, 1'b0, k - 1) : 1'b0;
    check($sformatf("%s k=%0d ready_m", tag, k),     32'(ready_m),     32'(e_ready));
    check($sformatf("%s k=%0d shift_en_m", tag, k),  32'(shift_en_m),  32'(e_shift));
    check($sformatf("%s k=%0d sdin_m", tag, k),      32'(sdin_m),      32'(e_sdin_m));
    check($sformatf("%s k=%0d out_valid_m", tag, k), 32'(out_valid_m), 32'(e_valid));
    check($sformatf("%s k=%0d bit_cnt_m", tag, k),   32'(bit_cnt_m),   32'(e_cnt));
    check($sformatf("%s k=%0d done_m", tag, k),      32'(done_m),      32'(e_done));
    check($sformatf("%s k=%0d ready_l", tag, k),     32'(ready_l),     32'(e_ready));
    check($sformatf("%s k=%0d shift_en_l", tag, k),  32'(shift_en_l),  32'(e_shift));
    check($sformatf("%s k=%0d sdin_l", tag, k),      32'(sdin_l),      32'(e_sdin_l));
    check($sformatf("%s k=%0d out_valid_l", tag, k), 32'(out_valid_l), 32'(e_valid));
    check($sformatf("%s k=%0d bit_cnt_l", tag, k),   32'(bit_cnt_l),   32'(e_cnt));
    check($sformatf("%s k=%0d done_l", tag, k),      32'(done_l),      32'(e_done));
  endtask

  // Entered just after a rising edge with the block idle. Sends word w,
  // raises abort in cycle abort_k (0 = never) and a stray start carrying
  // junk_w in cycle junk_k (0 = never). Callers keep junk_k inside the busy
  // window so the stray start must be ignored.
  task automatic run_frame(input string tag, input logic [WIDTH-1:0] w, input int abort_k,
                           input int junk_k, input logic [WIDTH-1:0] junk_w);
    start   = 1'b1;
    data_in = w;
    abort   = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= FRAME_LEN; k++) begin
      start   = (k == junk_k);
      data_in = (k == junk_k) ? junk_w : WIDTH'($urandom);
      abort   = (k == abort_k);
      @(negedge clk);
      check_cycle(tag, k, w, abort_k);
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] w, jw;
    int ak, jk;

    // Reset held for two cycles, then released.
    #1 rst = 1'b0;
    @(negedge clk);
    check_cycle("in_reset", 0, '0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_cycle("after_reset", 0, '0, 0);
    @(posedge clk); #1;

    // Directed frames.
    run_frame("a5", 8'hA5, 0, 0, '0);
    run_frame("01", 8'h01, 0, 0, '0);
    run_frame("00_stray_ff", 8'h00, 0, 3, 8'hFF);
    run_frame("abort_c10", 8'h3C, 10, 0, '0);
    run_frame("07", 8'h07, 0, 0, '0);
    run_frame("abort_c3", 8'hE7, 3, 2, 8'h5A);
    run_frame("abort_done", 8'h96, NB + DEPTH + 1, NB + DEPTH, 8'h11);

    // start and abort together in IDLE: abort wins, nothing is accepted.
    start = 1'b1; abort = 1'b1; data_in = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_cycle("idle_start_abort", 0, '0, 0);
    @(posedge clk); #1;

    // abort alone in IDLE has no effect.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_cycle("idle_abort", 0, '0, 0);
    @(posedge clk); #1;

    // Random frames with random aborts and stray starts.
    for (int f = 0; f < 10; f++) begin
      w  = WIDTH'($urandom);
      jw = WIDTH'($urandom);
      ak = ($urandom_range(1, 0) == 1) ? int'($urandom_range(NB + DEPTH + 1, 1)) : 0;
      jk = int'($urandom_range((ak == 0) ? (NB + DEPTH + 1) : ak, 1));
      run_frame($sformatf("rnd%0d", f), w, ak, jk, jw);
    end

    // Asynchronous reset in the middle of SHIFT.
    start = 1'b1; data_in = 8'hC3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    check("arst pre shift_en_m", 32'(shift_en_m), 32'd1);
    rst = 1'b0;
    #1;
    check_cycle("arst_async", 0, '0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_cycle("arst_release", 0, '0, 0);
    @(posedge clk); #1;
    run_frame("after_arst", 8'h5A, 0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
